// File: rtl/serial_magnitude_comparator_if.sv
// Handshake and result bundle for the bit-serial magnitude comparator.
// The master drives operand bits; the slave (comparator) returns status and the result.
interface serial_magnitude_comparator_if;
    logic start;
    logic bit_valid;
    logic a_bit;
    logic b_bit;
    logic busy;
    logic done;
    logic lt;
    logic gt;
    logic eq;

    modport master (
        output start, bit_valid, a_bit, b_bit,
        input  busy, done, lt, gt, eq
    );

    modport slave (
        input  start, bit_valid, a_bit, b_bit,
        output busy, done, lt, gt, eq
    );
endinterface

// File: rtl/serial_magnitude_comparator.sv
// LSB-first unsigned comparator: consumes one A/B bit pair per valid cycle and
// reports a registered one-hot lt/gt/eq result with a single-cycle done pulse.
module serial_magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_magnitude_comparator_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
    typedef enum logic [1:0] {REL_EQ, REL_LT, REL_GT} rel_t;

    state_t        state_q, state_d;
    rel_t          rel_q, rel_d, rel_new;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lt_q, lt_d;
    logic          gt_q, gt_d;
    logic          eq_q, eq_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rel_q   <= REL_EQ;
            cnt_q   <= '0;
            lt_q    <= 1'b0;
            gt_q    <= 1'b0;
            eq_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
            lt_q    <= lt_d;
            gt_q    <= gt_d;
            eq_q    <= eq_d;
        end
    end

    // Later (higher) bits override the relation built from lower bits.
    always_comb begin
        rel_new = rel_q;
        if (bus.a_bit && !bus.b_bit) begin
            rel_new = REL_GT;
        end else if (!bus.a_bit && bus.b_bit) begin
            rel_new = REL_LT;
        end
    end

    always_comb begin
        state_d = state_q;
        rel_d   = rel_q;
        cnt_d   = cnt_q;
        lt_d    = lt_q;
        gt_d    = gt_q;
        eq_d    = eq_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_SHIFT;
                    rel_d   = REL_EQ;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (bus.bit_valid) begin
                    rel_d = rel_new;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = ST_DONE;
                        lt_d    = (rel_new == REL_LT);
                        gt_d    = (rel_new == REL_GT);
                        eq_d    = (rel_new == REL_EQ);
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = (state_q == ST_DONE);
    assign bus.lt   = lt_q;
    assign bus.gt   = gt_q;
    assign bus.eq   = eq_q;
endmodule
